// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage redirect sequencer: turns mini-decode flags and EX flushes into one registered PC-mux redirect.
// Optional perf counters are enabled with `define FETCH_REDIR_PERF_EN.
module fetch_redirect_ctrl #(
  parameter int XLEN       = 32,
  parameter int PERF_CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc_if,
  input  logic            isjal,
  input  logic            isjalr,
  input  logic            isbxx,
  input  logic            predict_bxxtaken,
  input  logic            ismret,
  input  logic            isecallbk,
  input  logic [XLEN-1:0] jaloffset,
  input  logic [XLEN-1:0] bxxoffset,
  input  logic [XLEN-1:0] jalroffset,
  input  logic [XLEN-1:0] jalr_xn,
  input  logic            jalr_dep,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] mtvec,
  input  logic            pipe_empty,
  input  logic            exe_flush,
  input  logic [XLEN-1:0] exe_flush_pc,
  input  logic            redirect_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            fetch_stall,
  output logic            kill_if
`ifdef FETCH_REDIR_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_redirects,
  output logic [PERF_CNT_W-1:0] perf_stall_cycles
`endif
);

  // state      | meaning
  // IDLE       | fetch free-running, decoding IF flags
  // JALR_WAIT  | jalr base unresolved, IF held, offset latched
  // TRAP_DRAIN | ecall/ebreak seen, waiting for empty pipe
  // REDIR      | redirect_valid presented to PC mux
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    JALR_WAIT  = 2'd1,
    TRAP_DRAIN = 2'd2,
    REDIR      = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] off_q, off_d;
  logic [XLEN-1:0] jalr_sum;

  assign jalr_sum = jalr_xn + ((state_q == JALR_WAIT) ? off_q : jalroffset);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    off_d   = off_q;
    if (exe_flush) begin
      state_d = REDIR;
      pc_d    = exe_flush_pc;
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            if (isjal) begin
              state_d = REDIR;
              pc_d    = pc_if + jaloffset;
            end else if (isbxx && predict_bxxtaken) begin
              state_d = REDIR;
              pc_d    = pc_if + bxxoffset;
            end else if (isjalr && !jalr_dep) begin
              state_d = REDIR;
              pc_d    = {jalr_sum[XLEN-1:1], 1'b0};
            end else if (isjalr) begin
              state_d = JALR_WAIT;
              off_d   = jalroffset;
            end else if (ismret) begin
              state_d = REDIR;
              pc_d    = mepc;
            end else if (isecallbk) begin
              state_d = TRAP_DRAIN;
            end
          end
        end
        JALR_WAIT: begin
          if (!jalr_dep) begin
            state_d = REDIR;
            pc_d    = {jalr_sum[XLEN-1:1], 1'b0};
          end
        end
        TRAP_DRAIN: begin
          if (pipe_empty) begin
            state_d = REDIR;
            pc_d    = mtvec;
          end
        end
        REDIR: begin
          if (redirect_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      off_q   <= off_d;
    end
  end

  assign redirect_valid = (state_q == REDIR);
  assign redirect_pc    = pc_q;
  assign fetch_stall    = (state_q != IDLE);
  assign kill_if        = redirect_valid & redirect_ready;

`ifdef FETCH_REDIR_PERF_EN
  logic [PERF_CNT_W-1:0] redirects_q, redirects_d;
  logic [PERF_CNT_W-1:0] stalls_q, stalls_d;

  // Both counters saturate at all-ones rather than wrapping.
  always_comb begin
    redirects_d = redirects_q;
    stalls_d    = stalls_q;
    if (kill_if && (redirects_q != '1)) redirects_d = redirects_q + 1'b1;
    if (((state_q == JALR_WAIT) || (state_q == TRAP_DRAIN)) && (stalls_q != '1))
      stalls_d = stalls_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirects_q <= '0;
      stalls_q    <= '0;
    end else begin
      redirects_q <= redirects_d;
      stalls_q    <= stalls_d;
    end
  end

  assign perf_redirects    = redirects_q;
  assign perf_stall_cycles = stalls_q;
`else
  logic [PERF_CNT_W-1:0] unused_perf_w;
  assign unused_perf_w = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: directed scenarios plus randomized traffic vs. a reference model.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] pc_if = '0;
  logic        isjal = 1'b0, isjalr = 1'b0, isbxx = 1'b0, predict_bxxtaken = 1'b0;
  logic        ismret = 1'b0, isecallbk = 1'b0;
  logic [31:0] jaloffset = '0, bxxoffset = '0, jalroffset = '0, jalr_xn = '0;
  logic        jalr_dep = 1'b0;
  logic [31:0] mepc = '0, mtvec = '0;
  logic        pipe_empty = 1'b0, exe_flush = 1'b0;
  logic [31:0] exe_flush_pc = '0;
  logic        redirect_ready = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_stall, kill_if;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what is owed to the PC mux, and why fetch is held.
  bit          m_pending;
  bit          m_jalr_wait;
  bit          m_trap_wait;
  logic [31:0] m_target;
  logic [31:0] m_jalr_off;

  fetch_redirect_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .pc_if(pc_if),
    .isjal(isjal), .isjalr(isjalr), .isbxx(isbxx), .predict_bxxtaken(predict_bxxtaken),
    .ismret(ismret), .isecallbk(isecallbk), .jaloffset(jaloffset), .bxxoffset(bxxoffset),
    .jalroffset(jalroffset), .jalr_xn(jalr_xn), .jalr_dep(jalr_dep), .mepc(mepc), .mtvec(mtvec),
    .pipe_empty(pipe_empty), .exe_flush(exe_flush), .exe_flush_pc(exe_flush_pc),
    .redirect_ready(redirect_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_stall(fetch_stall), .kill_if(kill_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pending = 0; m_jalr_wait = 0; m_trap_wait = 0; m_target = '0; m_jalr_off = '0;
  endtask

  task automatic load(input logic [31:0] t);
    m_pending = 1; m_jalr_wait = 0; m_trap_wait = 0; m_target = t;
  endtask

  task automatic clear_inputs();
    instr_valid = 0; isjal = 0; isjalr = 0; isbxx = 0; predict_bxxtaken = 0;
    ismret = 0; isecallbk = 0; jalr_dep = 0; pipe_empty = 0; exe_flush = 0; redirect_ready = 0;
  endtask

  // One clock: check kill_if against current inputs, advance the model, check registered outputs.
  task automatic step();
    logic [31:0] sum;
    #1;
    check("kill_if", {31'b0, kill_if}, {31'b0, m_pending & redirect_ready});
    if (exe_flush) begin
      load(exe_flush_pc);
    end else if (m_pending) begin
      if (redirect_ready) m_pending = 0;
    end else if (m_jalr_wait) begin
      if (!jalr_dep) begin
        sum = jalr_xn + m_jalr_off;
        load(sum & 32'hFFFF_FFFE);
      end
    end else if (m_trap_wait) begin
      if (pipe_empty) load(mtvec);
    end else if (instr_valid) begin
      if (isjal) load(pc_if + jaloffset);
      else if (isbxx && predict_bxxtaken) load(pc_if + bxxoffset);
      else if (isjalr && !jalr_dep) begin
        sum = jalr_xn + jalroffset;
        load(sum & 32'hFFFF_FFFE);
      end else if (isjalr) begin
        m_jalr_wait = 1; m_jalr_off = jalroffset;
      end else if (ismret) load(mepc);
      else if (isecallbk) m_trap_wait = 1;
    end
    @(posedge clk);
    #1;
    check("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_pending});
    check("redirect_pc", redirect_pc, m_target);
    check("fetch_stall", {31'b0, fetch_stall},
          {31'b0, m_pending | m_jalr_wait | m_trap_wait});
  endtask

  task automatic rand_inputs();
    clear_inputs();
    instr_valid      = ($urandom_range(0, 3) != 0);
    pc_if            = $urandom();
    isjal            = ($urandom_range(0, 9) == 0);
    isjalr           = ($urandom_range(0, 5) == 0);
    isbxx            = ($urandom_range(0, 4) == 0);
    predict_bxxtaken = $urandom_range(0, 1);
    ismret           = ($urandom_range(0, 11) == 0);
    isecallbk        = ($urandom_range(0, 9) == 0);
    jaloffset        = $urandom();
    bxxoffset        = $urandom();
    jalroffset       = $urandom();
    jalr_xn          = $urandom();
    jalr_dep         = ($urandom_range(0, 2) != 0);
    mepc             = $urandom();
    mtvec            = $urandom();
    pipe_empty       = ($urandom_range(0, 3) == 0);
    exe_flush        = ($urandom_range(0, 11) == 0);
    exe_flush_pc     = $urandom();
    redirect_ready   = ($urandom_range(0, 4) < 3);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", {31'b0, redirect_valid}, 32'd0);
    check("reset_pc", redirect_pc, 32'd0);
    check("reset_stall", {31'b0, fetch_stall}, 32'd0);
    check("reset_kill", {31'b0, kill_if}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // jal 0x100 + 0x20, accepted immediately
    instr_valid = 1; isjal = 1; pc_if = 32'h100; jaloffset = 32'h20; redirect_ready = 1;
    step();
    check("jal_pc", redirect_pc, 32'h120);
    clear_inputs(); redirect_ready = 1;
    step();
    check("jal_back_idle", {31'b0, fetch_stall}, 32'd0);

    // jalr with base hazard for 3 cycles
    clear_inputs();
    instr_valid = 1; isjalr = 1; jalr_dep = 1; jalroffset = 32'h4; jalr_xn = 32'h0;
    repeat (3) begin
      step();
      check("jalr_wait_stall", {31'b0, fetch_stall}, 32'd1);
    end
    jalr_dep = 0; jalr_xn = 32'h2001; jalroffset = 32'h0;
    step();
    check("jalr_release_pc", redirect_pc, 32'h2004);
    clear_inputs(); redirect_ready = 1;
    step();

    // ecall drains for 5 cycles
    clear_inputs();
    instr_valid = 1; isecallbk = 1; mtvec = 32'h80;
    step();
    clear_inputs();
    repeat (5) step();
    check("trap_stall", {31'b0, fetch_stall}, 32'd1);
    pipe_empty = 1;
    step();
    check("trap_pc", redirect_pc, 32'h80);
    clear_inputs(); redirect_ready = 1;
    step();

    // flush overrides a stalled redirect
    clear_inputs();
    instr_valid = 1; isjal = 1; pc_if = 32'h100; jaloffset = 32'h20;
    step();
    clear_inputs();
    repeat (2) step();
    exe_flush = 1; exe_flush_pc = 32'h300;
    step();
    check("flush_pc", redirect_pc, 32'h300);
    exe_flush = 0;
    step();
    check("flush_held", redirect_pc, 32'h300);
    redirect_ready = 1;
    step();

    // not-taken branch, then wrapping jal
    clear_inputs();
    instr_valid = 1; isbxx = 1; predict_bxxtaken = 0; pc_if = 32'h40; bxxoffset = 32'h8;
    step();
    check("bxx_nt_stall", {31'b0, fetch_stall}, 32'd0);
    clear_inputs();
    instr_valid = 1; isjal = 1; pc_if = 32'hFFFF_FFF0; jaloffset = 32'h20;
    step();
    check("jal_wrap_pc", redirect_pc, 32'h10);
    clear_inputs(); redirect_ready = 1;
    step();

    // async reset while waiting on jalr
    clear_inputs();
    instr_valid = 1; isjalr = 1; jalr_dep = 1; jalroffset = 32'h8;
    step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_valid", {31'b0, redirect_valid}, 32'd0);
    check("arst_stall", {31'b0, fetch_stall}, 32'd0);
    check("arst_pc", redirect_pc, 32'd0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
